// File: rtl/bundler_seq_ctrl.sv
// bundler_seq_ctrl: time-multiplexed majority bundler.
// Accepts NUM_HVS hypervectors one per in_valid/in_ready handshake, keeps a
// per-dimension popcount, and emits a single majority-bundled hypervector.
// Ties (possible only for even NUM_HVS) are broken from TIE_HV.
//
// Ports:
//   clk       - clock, all state on rising edge
//   nrst      - asynchronous active-low reset
//   clear     - synchronous abort of the current bundle / pending result
//   in_valid  - in_hv valid
//   in_ready  - block can accept in_hv (registered, low only in DONE)
//   in_hv     - input hypervector
//   out_valid - out_hv holds a bundled result
//   out_ready - consumer accepts out_hv
//   out_hv    - bundled hypervector (held after delivery)
//   hv_count  - vectors accepted in the current bundle
//   busy      - high while accumulating or holding a result
module bundler_seq_ctrl #(
  parameter int unsigned            DIMENSIONS = 5,
  parameter int unsigned            NUM_HVS    = 5,
  parameter logic [DIMENSIONS-1:0]  TIE_HV     = 5'b10101
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DIMENSIONS-1:0]            in_hv,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DIMENSIONS-1:0]            out_hv,
  output logic [$clog2(NUM_HVS+1)-1:0]     hv_count,
  output logic                             busy
);

  localparam int unsigned CW = $clog2(NUM_HVS + 1);
  localparam logic [CW:0] NHV_W = (CW+1)'(NUM_HVS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_HVS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q [DIMENSIONS];
  logic [CW-1:0]         cnt_d [DIMENSIONS];
  logic [CW-1:0]         hv_count_q, hv_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DIMENSIONS-1:0] out_hv_q, out_hv_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  accept_c;
  logic                  last_c;
  logic [DIMENSIONS-1:0] maj_c;
  logic [CW:0]           dbl_c [DIMENSIONS];

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_hv    = out_hv_q;
  assign hv_count  = hv_count_q;
  assign busy      = busy_q;

  assign accept_c = in_valid && in_ready_q && !clear;

  // This accept completes the bundle (in IDLE only when bundling one vector)
  assign last_c = (state_q == IDLE) ? (NUM_HVS == 1) : (hv_count_q == LAST_CNT);

  // Majority including the vector being accepted this cycle; counters are 0 in IDLE
  always_comb begin
    maj_c = '0;
    for (int d = 0; d < DIMENSIONS; d++) begin
      dbl_c[d] = {cnt_q[d] + CW'(in_hv[d]), 1'b0};
      if (dbl_c[d] > NHV_W) begin
        maj_c[d] = 1'b1;
      end else if (dbl_c[d] == NHV_W) begin
        maj_c[d] = TIE_HV[d];
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hv_count_d  = hv_count_q;
    out_valid_d = out_valid_q;
    out_hv_d    = out_hv_q;

    if (clear) begin
      for (int d = 0; d < DIMENSIONS; d++) cnt_d[d] = '0;
      hv_count_d = '0;
      if (state_q == DONE) begin
        out_valid_d = 1'b0;
        out_hv_d    = '0;
      end
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept_c) begin
            if (last_c) begin
              out_hv_d    = maj_c;
              out_valid_d = 1'b1;
              for (int d = 0; d < DIMENSIONS; d++) cnt_d[d] = '0;
              hv_count_d  = '0;
              state_d     = DONE;
            end else begin
              for (int d = 0; d < DIMENSIONS; d++) cnt_d[d] = cnt_q[d] + CW'(in_hv[d]);
              hv_count_d = hv_count_q + CW'(1);
              state_d    = ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    in_ready_d = (state_d != DONE);
    busy_d     = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      for (int d = 0; d < DIMENSIONS; d++) cnt_q[d] <= '0;
      hv_count_q  <= '0;
      out_valid_q <= 1'b0;
      out_hv_q    <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hv_count_q  <= hv_count_d;
      out_valid_q <= out_valid_d;
      out_hv_q    <= out_hv_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_bundler_seq_ctrl.sv
// Directed testbench for bundler_seq_ctrl: a NUM_HVS=5 instance for the main
// scenarios and a NUM_HVS=4 instance for tie-breaking.
module tb_bundler_seq_ctrl;

  logic       clk;
  logic       nrst;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_hv;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_hv;
  logic [2:0] hv_count;
  logic       busy;

  logic       in_valid4;
  logic       in_ready4;
  logic [4:0] in_hv4;
  logic       out_valid4;
  logic       out_ready4;
  logic [4:0] out_hv4;
  logic [2:0] hv_count4;
  logic       busy4;

  int vectors_applied = 0;
  int miscompares     = 0;

  logic [4:0] s1_vecs [5] = '{5'b01101, 5'b00111, 5'b01111, 5'b00011, 5'b00011};
  logic [4:0] s2_vecs [4] = '{5'b11001, 5'b10100, 5'b01011, 5'b00011};

  bundler_seq_ctrl #(.DIMENSIONS(5), .NUM_HVS(5), .TIE_HV(5'b10101)) u_dut (
    .clk(clk), .nrst(nrst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_hv(in_hv),
    .out_valid(out_valid), .out_ready(out_ready), .out_hv(out_hv),
    .hv_count(hv_count), .busy(busy)
  );

  bundler_seq_ctrl #(.DIMENSIONS(5), .NUM_HVS(4), .TIE_HV(5'b10101)) u_dut4 (
    .clk(clk), .nrst(nrst), .clear(1'b0),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_hv(in_hv4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_hv(out_hv4),
    .hv_count(hv_count4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed scenario-1 vectors back to back; leaves in_valid low, block in DONE
  task automatic feed_s1(input logic rdy);
    out_ready = rdy;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_hv    = s1_vecs[i];
      tick();
    end
    in_valid = 1'b0;
    check("s1_out_valid", 32'(out_valid), 32'd1);
    check("s1_out_hv",    32'(out_hv),    32'h07);
    check("s1_in_ready",  32'(in_ready),  32'd0);
    check("s1_hv_count",  32'(hv_count),  32'd0);
  endtask

  initial begin
    nrst       = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_hv      = '0;
    out_ready  = 1'b0;
    in_valid4  = 1'b0;
    in_hv4     = '0;
    out_ready4 = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_hv",    32'(out_hv),    32'd0);
    check("rst_hv_count",  32'(hv_count),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    nrst = 1'b1;
    tick();

    // 1: back-to-back bundle, consumer ready
    feed_s1(1'b1);
    tick();
    check("s1_drain_valid", 32'(out_valid), 32'd0);
    check("s1_drain_ready", 32'(in_ready),  32'd1);
    check("s1_drain_busy",  32'(busy),      32'd0);
    check("s1_hold_hv",     32'(out_hv),    32'h07);

    // 2: even bundle with ties
    out_ready4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid4 = 1'b1;
      in_hv4    = s2_vecs[i];
      tick();
      if (i == 2) check("s2_hv_count3", 32'(hv_count4), 32'd3);
    end
    in_valid4 = 1'b0;
    check("s2_out_valid", 32'(out_valid4), 32'd1);
    check("s2_out_hv",    32'(out_hv4),    32'h11);
    out_ready4 = 1'b1;
    tick();
    check("s2_drain_valid", 32'(out_valid4), 32'd0);
    check("s2_drain_ready", 32'(in_ready4),  32'd1);

    // 3: backpressure with a stalled input
    feed_s1(1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_hv    = 5'b11111;
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_hv",    32'(out_hv),    32'h07);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_hv_count",  32'(hv_count),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    feed_s1(1'b1);
    tick();

    // 4: gaps between accepts
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_hv    = s1_vecs[i];
      tick();
      if (i < 4) begin
        check("gap_hv_count", 32'(hv_count), 32'(i + 1));
        check("gap_busy",     32'(busy),     32'd1);
        in_valid = 1'b0;
        in_hv    = 5'b11111;
        tick();
        check("gap_hold_cnt", 32'(hv_count), 32'(i + 1));
      end
    end
    in_valid = 1'b0;
    check("gap_out_valid", 32'(out_valid), 32'd1);
    check("gap_out_hv",    32'(out_hv),    32'h07);
    tick();

    // 5: clear mid-bundle drops the concurrent vector
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_hv    = s1_vecs[i];
      tick();
    end
    clear = 1'b1;
    in_hv = 5'b11111;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_hv_count", 32'(hv_count),  32'd0);
    check("clr_busy",     32'(busy),      32'd0);
    check("clr_in_ready", 32'(in_ready),  32'd1);
    check("clr_out_valid",32'(out_valid), 32'd0);
    feed_s1(1'b1);
    tick();
    // clear in DONE beats a simultaneous handshake
    feed_s1(1'b0);
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_done_valid", 32'(out_valid), 32'd0);
    check("clr_done_hv",    32'(out_hv),    32'd0);
    check("clr_done_busy",  32'(busy),      32'd0);

    // 6: async reset in DONE between edges
    feed_s1(1'b0);
    #3;
    nrst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_hv",    32'(out_hv),    32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    #2;
    nrst = 1'b1;
    tick();
    check("arst_rel_ready", 32'(in_ready), 32'd1);
    feed_s1(1'b1);
    tick();
    check("arst_final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/bundler_seq_ctrl.md
Name: bundler_seq_ctrl

Overview:
Time-multiplexed sequencer for hypervector bundling. It accepts NUM_HVS hypervectors one per handshake over a single DIMENSIONS-wide input instead of a parallel array. It keeps per-dimension bit counters and, after the last vector, issues one majority-bundled hypervector, breaking ties from a fixed tie vector. It sits between the encoder output stream and the class/associative-memory stage, and replaces the parallel bundler where area matters.

Parameters:
DIMENSIONS, 5, hypervector width in bits
NUM_HVS, 5, number of hypervectors bundled per result (>=1; odd or even)
TIE_HV, 5'b10101, DIMENSIONS-bit tie-break vector, used per bit when count*2 == NUM_HVS
CW, $clog2(NUM_HVS+1), derived localparam: counter width

Ports:
clk  input  1  clock, all state on rising edge
nrst  input  1  asynchronous active-low reset
clear  input  1  synchronous abort of current bundle
in_valid  input  1  in_hv valid
in_ready  output  1  block can accept in_hv
in_hv  input  DIMENSIONS  input hypervector
out_valid  output  1  out_hv holds a bundled result
out_ready  input  1  consumer accepts out_hv
out_hv  output  DIMENSIONS  bundled hypervector
hv_count  output  CW  vectors accepted in current bundle
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (nrst=0, async): state=IDLE; all bit counters=0; hv_count=0; out_valid=0; out_hv=0; busy=0; in_ready=1.
- Accept event: in_valid && in_ready && !clear.
- in_ready = (state != DONE). It is derived from registered state only, with no combinational path from inputs.
- IDLE: on accept, cnt[d] <= in_hv[d] for every d, hv_count <= 1, go to ACCUM. If NUM_HVS==1, go directly to DONE instead, applying the finalize rule.
- ACCUM: on accept, cnt[d] <= cnt[d] + in_hv[d] and hv_count += 1. If this accept is the NUM_HVS-th vector (hv_count == NUM_HVS-1 before the accept), finalize and go to DONE. With in_valid=0, hold.
- Finalize, same edge as the last accept: s[d] = cnt[d] + in_hv[d].
  - out_hv[d] = 1 if 2*s[d] > NUM_HVS.
  - out_hv[d] = 0 if 2*s[d] < NUM_HVS.
  - out_hv[d] = TIE_HV[d] if 2*s[d] == NUM_HVS (possible only for even NUM_HVS).
  - Then out_valid <= 1, counters <= 0, hv_count <= 0.
  - Counter arithmetic is unsigned CW-bit and cannot overflow, since a count is at most NUM_HVS.
- Latency: out_valid rises the cycle after the final accept.
- DONE: out_valid=1, and out_hv is held stable until out_valid && out_ready. On that handshake, out_valid <= 0 and go to IDLE. in_ready=0, so in_valid is ignored with no counter change. Result-to-next-accept bubble is one cycle.
- clear, synchronous, highest priority over everything except reset:
  - IDLE/ACCUM: counters and hv_count <= 0, go to IDLE. A concurrent in_valid vector is discarded.
  - DONE: out_valid <= 0, out_hv <= 0, go to IDLE, even if out_ready=1 in the same cycle.
- out_hv outside DONE keeps the last delivered value. It is 0 after reset or after clear in DONE.
- busy = (state == ACCUM) || (state == DONE).
- Reset asserted mid-bundle or in DONE discards everything immediately. No partial result is ever emitted.

Test Plan:
1. DIMENSIONS=5, NUM_HVS=5, TIE_HV=5'b10101; accept 01101, 00111, 01111, 00011, 00011 on back-to-back cycles with out_ready=1 -> out_valid one cycle after the 5th accept with out_hv=00111 (bit counts b4..b0 = 0,2,3,4,5); in_ready=0 that cycle; IDLE and in_ready=1 next cycle.
2. NUM_HVS=4, TIE_HV=5'b10101; inputs 11001, 10100, 01011, 00011 -> counts 2,2,1,2,3 -> out_hv=10001 (bits 4, 3 and 1 come from TIE_HV).
3. Backpressure: complete scenario 1 with out_ready=0 for 3 cycles while in_valid=1 with 11111 -> out_hv stays 00111, in_ready=0, hv_count=0; after out_ready=1 the next bundle starts with clean counters.
4. Gaps and hv_count: insert in_valid=0 cycles between the vectors of scenario 1 -> hv_count steps 1..4, busy=1, and the result is identical (00111).
5. clear: after 2 accepts, assert clear with in_valid=1 and in_hv=11111 -> vector dropped, hv_count=0, IDLE; then the scenario 1 vectors give 00111. clear in DONE with out_ready=1 -> no handshake, out_valid=0, out_hv=0.
6. Async reset: drop nrst in DONE between clock edges -> out_valid=0, out_hv=0 and busy=0 before the next edge; after release, in_ready=1 and the scenario 1 vectors give 00111.
